// File: rtl/branch_pred_ctrl_if.sv
// Fetch/execute handshake bundle between the pipeline and the branch predictor.
// The pipeline drives lookups and resolutions; the predictor returns prediction and redirect.
interface branch_pred_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_jalr;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     br_count;
    logic [31:0]     mp_count;

    modport master (
        output if_valid, if_pc, ex_valid, ex_branch, ex_jump, ex_jalr, ex_pc,
               ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, flush, redirect_pc, br_count, mp_count
    );

    modport slave (
        input  if_valid, if_pc, ex_valid, ex_branch, ex_jump, ex_jalr, ex_pc,
               ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, flush, redirect_pc, br_count, mp_count
    );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Direct-mapped BTB with 2-bit counters: IF lookup, EX resolve/update, mispredict flush.
// Optional perf counters (br_count/mp_count) enabled by defining BP_PERF_CNT_EN.
module branch_pred_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_pred_ctrl_if.slave bp
);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic             tbl_valid [DEPTH];
    logic [1:0]       tbl_ctr   [DEPTH];
    logic [TAG_W-1:0] tbl_tag   [DEPTH];
    logic [XLEN-1:0]  tbl_tgt   [DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             if_hit;
    logic             ex_hit;
    logic             pred_taken_c;
    logic             upd;
    logic             mispredict;
    logic [XLEN-1:0]  if_seq_pc;
    logic [XLEN-1:0]  ex_seq_pc;

    assign if_idx    = bp.if_pc[IDX_W+1:2];
    assign if_tag    = bp.if_pc[XLEN-1:IDX_W+2];
    assign ex_idx    = bp.ex_pc[IDX_W+1:2];
    assign ex_tag    = bp.ex_pc[XLEN-1:IDX_W+2];
    assign if_seq_pc = bp.if_pc + XLEN'(4);
    assign ex_seq_pc = bp.ex_pc + XLEN'(4);

    // Lookup reads the table state before this cycle's update (no bypass).
    assign if_hit       = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
    assign pred_taken_c = bp.if_valid && if_hit && tbl_ctr[if_idx][1];
    assign bp.pred_taken  = pred_taken_c;
    assign bp.pred_target = pred_taken_c ? tbl_tgt[if_idx] : if_seq_pc;

    // EX inputs are ignored while reset is asserted.
    assign upd = rst_n && bp.ex_valid && (bp.ex_branch || bp.ex_jump || bp.ex_jalr);
    assign mispredict = upd && ((bp.ex_taken != bp.ex_pred_taken) ||
                                (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
    assign bp.flush       = mispredict;
    assign bp.redirect_pc = !mispredict ? '0 : (bp.ex_taken ? bp.ex_target : ex_seq_pc);

    assign ex_hit = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);

    // Table update; jalr never touches the table and takes priority over jal/branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_ctr[i]   <= 2'b01;
                tbl_tag[i]   <= '0;
                tbl_tgt[i]   <= '0;
            end
        end else if (upd && !bp.ex_jalr) begin
            if (bp.ex_jump) begin
                tbl_valid[ex_idx] <= 1'b1;
                tbl_tag[ex_idx]   <= ex_tag;
                tbl_tgt[ex_idx]   <= bp.ex_target;
                tbl_ctr[ex_idx]   <= 2'b11;
            end else if (ex_hit) begin
                if (bp.ex_taken) begin
                    tbl_tgt[ex_idx] <= bp.ex_target;
                    if (tbl_ctr[ex_idx] != 2'b11) tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] + 2'd1;
                end else if (tbl_ctr[ex_idx] != 2'b00) begin
                    tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] - 2'd1;
                end
            end else if (bp.ex_taken) begin
                tbl_valid[ex_idx] <= 1'b1;
                tbl_tag[ex_idx]   <= ex_tag;
                tbl_tgt[ex_idx]   <= bp.ex_target;
                tbl_ctr[ex_idx]   <= 2'b10;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mp_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (upd && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_q <= br_cnt_q + 32'd1;
            if (mispredict && (mp_cnt_q != 32'hFFFF_FFFF)) mp_cnt_q <= mp_cnt_q + 32'd1;
        end
    end

    assign bp.br_count = br_cnt_q;
    assign bp.mp_count = mp_cnt_q;
`else
    assign bp.br_count = '0;
    assign bp.mp_count = '0;
`endif
endmodule
